// File: rtl/partoserial_sched.sv
// partoserial_sched
//   Round-robin byte scheduler sharing one partoserial converter among four
//   byte requesters on the clk_32f domain. One requester is granted per
//   8-cycle serial frame. Its byte is held on data_out/valid_out for the
//   whole frame. Idle frames carry IDLE_BYTE with valid_out low.
//
//   Build option: define PARTOSERIAL_SCHED_PRIO_EN to use strict priority,
//   where the lowest valid index wins, instead of round-robin. With this
//   option defined there is no rotating pointer.
//
// Ports
//   clk_32f     in   bit clock, the only clock in the block
//   reset       in   asynchronous active-low reset
//   req_valid   in   [NUM_REQ-1:0]   requester i offers a byte
//   req_data    in   [8*NUM_REQ-1:0] byte of requester i at [8i+7:8i]
//   req_ready   out  [NUM_REQ-1:0]   one-hot combinational grant in the grant slot
//   data_out    out  [7:0]  byte to partoserial.data_in, held for one frame
//   valid_out   out         to partoserial.valid_in
//   lane_id     out  [1:0]  requester whose byte is on data_out
//   frame_start out         high during slot 0 of each frame
module partoserial_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [7:0]  IDLE_BYTE   = 8'hBC,
    parameter int unsigned SYNC_FRAMES = 2
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           data_out,
    output logic                 valid_out,
    output logic [1:0]           lane_id,
    output logic                 frame_start
);

    typedef enum logic [1:0] {
        INIT,
        SYNC,
        ACTIVE
    } state_t;

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_FRAMES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] slot;
    logic [7:0] sync_cnt;
    logic       grant_slot;
    logic       found;
    logic [1:0] win;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // The slot-7 cycle of the final SYNC frame is already a grant cycle.
    // This makes the first byte go out in the first ACTIVE frame.
    always_comb begin
        state_next = state;
        grant_slot = 1'b0;
        req_ready  = '0;
        case (state)
            INIT: state_next = SYNC;
            SYNC: begin
                if (slot == 3'd7 && sync_cnt == SYNC_LAST) begin
                    state_next = ACTIVE;
                    grant_slot = 1'b1;
                end
            end
            ACTIVE: grant_slot = (slot == 3'd7);
            default: state_next = INIT;
        endcase
        if (grant_slot && found) begin
            req_ready[win] = 1'b1;
        end
    end

`ifdef PARTOSERIAL_SCHED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[k]) begin
                found = 1'b1;
                win   = k[1:0];
            end
        end
    end
`else
    logic [1:0] rr_ptr;
    logic [1:0] idx;

    // The search starts at rr_ptr and wraps modulo 4 through 2-bit addition.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + k[1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (grant_slot && found) begin
            rr_ptr <= win + 2'd1;
        end
    end
`endif

    // slot stays at 0 in INIT, so the first SYNC cycle is slot 0.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            slot        <= '0;
            sync_cnt    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (state == INIT) || (slot == 3'd7);
            if (state != INIT) begin
                slot <= slot + 3'd1;
                if (state == SYNC && slot == 3'd7) begin
                    sync_cnt <= sync_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_id   <= '0;
        end else if (state == INIT) begin
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
        end else if (grant_slot) begin
            if (found) begin
                data_out  <= req_data[{win, 3'b000} +: 8];
                valid_out <= 1'b1;
                lane_id   <= win;
            end else begin
                data_out  <= IDLE_BYTE;
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_partoserial_sched.sv
// Self-checking bench for partoserial_sched with a cycle-indexed reference model.
// The model counts clock edges since reset release and derives slot and frame
// position from that count with plain arithmetic.
module tb_partoserial_sched;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int         SYNC_FRAMES = 2;

    logic        clk_32f = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_id;
    logic        frame_start;

    partoserial_sched #(
        .NUM_REQ(4),
        .IDLE_BYTE(8'hBC),
        .SYNC_FRAMES(2)
    ) dut (
        .clk_32f(clk_32f),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .data_out(data_out),
        .valid_out(valid_out),
        .lane_id(lane_id),
        .frame_start(frame_start)
    );

    always #5 clk_32f = ~clk_32f;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    // t is the number of clock edges since reset release.
    // Cycle t >= 1 is slot (t-1)%8.
    bit         in_reset = 1'b1;
    int         t = 0;
    int         rr = 0;
    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0;
    logic [1:0] m_lane = '0;

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
`ifdef PARTOSERIAL_SCHED_PRIO_EN
            int i = k;
`else
            int i = (ptr + k) % 4;
`endif
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit grant_cycle();
        return !in_reset && t >= 8 * SYNC_FRAMES && ((t - 1) % 8) == 7;
    endfunction

    function automatic int cur_slot();
        return (in_reset || t == 0) ? -1 : (t - 1) % 8;
    endfunction

    function automatic logic [15:0] expected();
        logic [3:0] rdy;
        logic       fs;
        int         w;
        rdy = '0;
        w = pick(req_valid, rr);
        if (grant_cycle() && w >= 0) rdy[w] = 1'b1;
        fs = (cur_slot() == 0);
        return {rdy, m_data, m_valid, m_lane, fs};
    endfunction

    task automatic model_edge();
        int w;
        if (in_reset) return;
        if (t == 0) begin
            m_data  = IDLE;
            m_valid = 1'b0;
        end else if (grant_cycle()) begin
            w = pick(req_valid, rr);
            if (w >= 0) begin
                m_data  = req_data[w*8 +: 8];
                m_valid = 1'b1;
                m_lane  = w[1:0];
                rr      = (w + 1) % 4;
            end else begin
                m_data  = IDLE;
                m_valid = 1'b0;
            end
        end
        t++;
    endtask

    task automatic tick();
        @(posedge clk_32f);
        model_edge();
        @(negedge clk_32f);
    endtask

    task automatic assert_reset();
        reset    = 1'b0;
        in_reset = 1'b1;
        t        = 0;
        rr       = 0;
        m_data   = '0;
        m_valid  = 1'b0;
        m_lane   = '0;
    endtask

    task automatic release_reset();
        reset    = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8; i++) begin
            if (cur_slot() == s) break;
            tick();
        end
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        assert_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i,
                         {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
            end
            tick();
        end
        release_reset();
        for (int i = 0; i <= 16; i++) begin
            #1;
            vectors++;
            if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                miscompares++;
                $display("FAIL sync_seq t=%0d got=%h exp=%h", t,
                         {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
            end
            if (t == 16) begin
                vectors++;
                if (req_ready !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL first_grant got=%b exp=0001", req_ready);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        for (int i = 0; i < 64; i++) begin
            #1;
            vectors++;
            if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                miscompares++;
                $display("FAIL round_robin t=%0d got=%h exp=%h", t,
                         {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
            end
            tick();
        end
    endtask

    task automatic test_sparse();
        wait_slot(0);
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        for (int i = 0; i < 24; i++) begin
            if (i == 8) req_valid = 4'b0000;
            #1;
            vectors++;
            if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                miscompares++;
                $display("FAIL sparse t=%0d got=%h exp=%h", t,
                         {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
            end
            tick();
        end
        #1;
        vectors++;
        if ({data_out, valid_out, lane_id} !== {8'hBC, 1'b0, 2'd2}) begin
            miscompares++;
            $display("FAIL sparse_idle_hold got=%h/%b/%0d exp=bc/0/2", data_out, valid_out, lane_id);
        end
    endtask

    task automatic test_pointer_skip();
        logic [1:0] second_lane;
`ifdef PARTOSERIAL_SCHED_PRIO_EN
        second_lane = 2'd1;
`else
        second_lane = 2'd3;
`endif
        wait_slot(0);
        req_valid = 4'b1000;
        req_data  = 32'h77006600;
        for (int i = 0; i < 32; i++) begin
            if (i == 8) req_valid = 4'b1010;
            if (i == 24) req_valid = 4'b0000;
            #1;
            vectors++;
            if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                miscompares++;
                $display("FAIL ptr_skip t=%0d got=%h exp=%h", t,
                         {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
            end
            if (i == 16) begin
                vectors++;
                if ({lane_id, data_out} !== {2'd1, 8'h66}) begin
                    miscompares++;
                    $display("FAIL ptr_skip_lane1 got=%0d/%h exp=1/66", lane_id, data_out);
                end
            end
            if (i == 24) begin
                vectors++;
                if (lane_id !== second_lane) begin
                    miscompares++;
                    $display("FAIL ptr_skip_second got=%0d exp=%0d", lane_id, second_lane);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            wait_slot(0);
            req_valid = 4'($urandom_range(0, 15));
            req_data  = $urandom;
            for (int i = 0; i < 8; i++) begin
                #1;
                vectors++;
                if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                    miscompares++;
                    $display("FAIL random t=%0d got=%h exp=%h", t,
                             {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        wait_slot(0);
        req_valid = 4'b0001;
        req_data  = 32'h0000005A;
        for (int i = 0; i < 8; i++) tick();
        req_valid = 4'b0000;
        wait_slot(4);
        #1;
        vectors++;
        if ({data_out, valid_out} !== {8'h5A, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_frame_pre got=%h/%b exp=5a/1", data_out, valid_out);
        end
        assert_reset();
        #1;
        vectors++;
        if ({data_out, valid_out, req_ready, frame_start} !== {8'h00, 1'b0, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got=%h/%b/%b/%b exp=00/0/0000/0",
                     data_out, valid_out, req_ready, frame_start);
        end
        @(negedge clk_32f);
        req_valid = 4'hF;
        req_data  = 32'h44332211;
        for (int i = 0; i < 3; i++) tick();
        release_reset();
        for (int i = 0; i < 26; i++) begin
            #1;
            vectors++;
            if ({req_ready, data_out, valid_out, lane_id, frame_start} !== expected()) begin
                miscompares++;
                $display("FAIL resync t=%0d got=%h exp=%h", t,
                         {req_ready, data_out, valid_out, lane_id, frame_start}, expected());
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk_32f);
        test_reset();
        test_round_robin();
        test_sparse();
        test_pointer_skip();
        test_random();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
